// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the overflow-flagged register bank.
package reg_bank_pkg;

    typedef enum logic {
        CLR_IDLE,
        CLR_SWEEP
    } clr_state_t;

    function automatic logic addr_ok(
        input int unsigned addr,
        input int unsigned depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_entry.sv
// One bank entry: WIDTH-bit data register plus its overflow flag.
module reg_entry
    import reg_bank_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit STICKY_OFL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic             ofl,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q,
    output logic             flag
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             flag_d, flag_q;

    // Fixed priority: clear beats load beats shift.
    always_comb begin
        data_d = data_q;
        flag_d = flag_q;
        if (clr) begin
            data_d = '0;
            flag_d = 1'b0;
        end else if (ld) begin
            data_d = data;
            flag_d = STICKY_OFL ? (flag_q | ofl) : ofl;
        end else if (shift) begin
            data_d = {shift_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            flag_q <= 1'b0;
        end else begin
            data_q <= data_d;
            flag_q <= flag_d;
        end
    end

    assign q    = data_q;
    assign flag = flag_q;

endmodule

// File: rtl/reg_bank_ofl.sv
// Bank of DEPTH overflow-flagged registers with addressed load/shift,
// two combinational read ports and a one-entry-per-cycle clear sweep.
module reg_bank_ofl
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int DEPTH      = 4,
    parameter  bit STICKY_OFL = 1'b0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Ld,
    input  logic [AW-1:0]    Ld_Addr,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Ofl,
    input  logic             Shift,
    input  logic [AW-1:0]    Shift_Addr,
    input  logic             Shift_In,
    input  logic             Clr_Start,
    output logic             Clr_Busy,
    input  logic [AW-1:0]    Rd_Addr_A,
    input  logic [AW-1:0]    Rd_Addr_B,
    output logic [WIDTH-1:0] Data_Out_A,
    output logic [WIDTH-1:0] Data_Out_B,
    output logic             Overflow_A,
    output logic             Overflow_B,
    output logic             Ofl_Any
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t       state_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q;

    logic [DEPTH-1:0] clr_v, ld_v, sh_v;
    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_flag;
    logic             ld_ok, sh_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                CLR_IDLE: begin
                    if (Clr_Start) begin
                        state_q <= CLR_SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    if (idx_q == LAST) begin
                        state_q <= CLR_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Commands arriving during the sweep are dropped, not queued.
    assign ld_ok = Ld && !busy_q && addr_ok(32'(Ld_Addr), DEPTH);
    assign sh_ok = Shift && !busy_q && addr_ok(32'(Shift_Addr), DEPTH);

    always_comb begin
        clr_v = '0;
        ld_v  = '0;
        sh_v  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_v[i] = busy_q && (idx_q == AW'(i));
            ld_v[i]  = ld_ok && (Ld_Addr == AW'(i));
            sh_v[i]  = sh_ok && (Shift_Addr == AW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        reg_entry #(
            .WIDTH      (WIDTH),
            .STICKY_OFL (STICKY_OFL)
        ) u_ent (
            .clk      (Clk),
            .rst_n    (Reset_n),
            .clr      (clr_v[g]),
            .ld       (ld_v[g]),
            .shift    (sh_v[g]),
            .data     (Data_In),
            .ofl      (Ofl),
            .shift_in (Shift_In),
            .q        (ent_data[g]),
            .flag     (ent_flag[g])
        );
    end

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        Data_Out_A = '0;
        Data_Out_B = '0;
        Overflow_A = 1'b0;
        Overflow_B = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Rd_Addr_A == AW'(i)) begin
                Data_Out_A = ent_data[i];
                Overflow_A = ent_flag[i];
            end
            if (Rd_Addr_B == AW'(i)) begin
                Data_Out_B = ent_data[i];
                Overflow_B = ent_flag[i];
            end
        end
    end

    assign Ofl_Any  = |ent_flag;
    assign Clr_Busy = busy_q;

endmodule
